fp8_to_int_code: RTL and testbench
==================================

# fp8_to_int_code

Pipelined e4m3 float8 → integer exponent-code converter: the inverse of the exponent-to-float8 path in the log-fp8 datapath. Each accepted e4m3 value is rounded to the nearest integer k. k is saturated to [-7, +8] and emitted as the biased 4-bit code k+7, the same code space the float8 encoder consumes. Zero, saturation and NaN flags travel with each result. The block sits at the front of the log domain and streams over a valid/ready handshake at one result per cycle.

## Interface
- `OUT_REG_RESET_CODE`, default 4'd7 — value of `out_code` after reset (code for k=0).
- `clk`  input  1  — sole clock, rising edge.
- `rst_n`  input  1  — reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- `in_valid`  input  1  — `in_data` valid.
- `in_ready`  output  1  — block can accept this cycle.
- `in_data`  input  8  — e4m3: {sign, exp[3:0], mant[2:0]}, bias 7.
- `out_valid`  output  1  — result valid.
- `out_ready`  input  1  — consumer accepts.
- `out_code`  output  4  — biased integer code, k+7.
- `out_zero`  output  1  — input was exactly ±0.
- `out_sat`  output  1  — rounded k was outside [-7, +8] and was clamped.
- `out_nan`  output  1  — input was NaN (S.1111.111).

## Operation
- Transfer occurs on a cycle with valid && ready on either side.
- **Stage 1 (S1):** register the sign, the rounded magnitude r (5 bits, saturated at 16), and the zero and NaN flags.
- **Rounding rule:** round to nearest, ties away from zero.
  - E≤5 → 0; E=6 → 1.
  - E=7: M<4 → 1, else 2.
  - E=8: M≤1 → 2; M 2..5 → 3; M 6..7 → 4.
  - E=9: M → {4,5,5,6,6,7,7,8}.
  - E=10, M=0 → 8.
  - Any other E≥10 → 16, which marks overflow.
- **Stage 2 (S2):** compute k = sign ? −r : r.
  - k>8 → k=8, sat=1.
  - k<−7 → k=−7, sat=1.
  - `out_code` = k+7, computed mod 16 in 4-bit arithmetic.
- **Zero:** ±0 gives code 7, zero=1, sat=0.
  - −0 is treated as +0.
  - A nonzero subnormal also gives code 7, but with zero=0.
- **NaN:** code 0, nan=1, sat=0, zero=0.
- **Flag exclusivity:** at most one of zero/sat/nan is ever set.
- **Pipeline control:** each stage is a valid bit plus payload.
  - stage_ready = !stage_valid || next_ready.
  - `in_ready` = S1 ready.
  - Output ports are driven directly from S2 registers; there is no output combinational logic.
- **Stall:** when `out_ready`=0 with S2 full, S2 holds its payload unchanged.
  - S1 also holds if it is full.
  - `in_ready` deasserts only when both stages are full.

## Timing
- **Latency:** 2 cycles. Input accepted on edge n → `out_valid` high after edge n+1, visible in cycle n+2.
- **Throughput:** 1 per cycle when `out_ready` is held high.
- **Reset:** on a `rst_n`=0 sample, both valid bits clear.
  - `out_code` = OUT_REG_RESET_CODE; `out_zero`/`out_sat`/`out_nan` = 0.
  - `in_ready`=1 in the first cycle after reset deasserts.
- **Reset mid-stream:** in-flight data is discarded and nothing is replayed.
- **Simultaneous events:** S2 draining and S1 advancing in the same cycle is legal; a full pipeline with `out_ready`=1 accepts a new input in that cycle.
- **Output stability:** `out_*` payload is stable while `out_valid` && !`out_ready`.

## Configuration
- `FP8_TO_INT_STATS_EN` defined: adds output ports `stat_sat_cnt`[15:0] and `stat_nan_cnt`[15:0].
  - Each counts output transfers carrying sat or nan respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package `fp8_pkg`:**
  - e4m3 field widths/offsets, bias 7.
  - Constants CODE_MIN_K=−7, CODE_MAX_K=8, CODE_BIAS=7.
  - NaN pattern 7'h7F (sign excluded).
  - Typedef for the S1 payload struct.
- **One sub-module, `fp8_round_mag`:** purely combinational {E,M} → 5-bit rounded magnitude, plus zero/nan detect. It is reused by future float-to-log paths.
- **Top module:** handshake, the two stages, and the optional statistics counters.

## Test plan
- Single transfers with `out_ready`=1:
  - 0x38 (1.0) → code 8.
  - 0x44 (3.0) → code 10.
  - 0xC0 (−2.0) → code 5.
  - Each appears 2 cycles after acceptance with all flags 0.
- Rounding ties and small values:
  - 0x3C (1.5) → code 9.
  - 0x4A (5.0) → code 12.
  - 0x4B (5.5) → code 13.
  - 0x30 (0.5) → code 8.
  - 0x28 (0.25) → code 7.
  - 0x01 (subnormal) → code 7, zero=0.
- Specials and saturation:
  - 0x00 and 0x80 → code 7, zero=1.
  - 0x58 (16) → code 15, sat=1.
  - 0xD8 (−16) → code 0, sat=1.
  - 0xC0|0x10 = 0xD0 (−8) → code 0, sat=1.
  - 0x7F/0xFF → code 0, nan=1.
- Backpressure:
  - Stream 0x38,0x40,0x44,0x48 with `out_ready` low for 3 cycles.
  - Required: `in_ready` drops after 2 accepts, output holds code 8 stable, then drains 8,9,10,11 in order with no loss or duplication.
- Reset mid-stream: assert `rst_n`=0 for 1 cycle with both stages full → next cycle `out_valid`=0, `out_code`=7, `in_ready`=1.
- With `FP8_TO_INT_STATS_EN`: send 3 sat inputs and 2 NaN inputs → `stat_sat_cnt`=3, `stat_nan_cnt`=2.
  - Stalled (un-transferred) outputs are not counted.

Source files
------------

// File: rtl/fp8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp8_pkg
// Description : Shared definitions for the log-fp8 datapath. Holds the e4m3
//               field layout, the integer exponent-code range, the NaN
//               pattern and the stage-1 payload of the fp8 -> code converter.
// Revision    : 1.0  initial release
// ============================================================================
package fp8_pkg;

    // e4m3 layout: {sign, exp[3:0], mant[2:0]}, exponent bias 7
    localparam int E4M3_W   = 8;
    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int EXP_W    = 4;
    localparam int MANT_MSB = 2;
    localparam int MANT_LSB = 0;
    localparam int MANT_W   = 3;
    localparam int EXP_BIAS = 7;

    // Integer exponent-code space shared with the float8 encoder
    localparam int CODE_MIN_K = -7;
    localparam int CODE_MAX_K = 8;
    localparam int CODE_BIAS  = 7;
    localparam int CODE_W     = 4;

    // Rounded magnitude width; value 16 flags overflow
    localparam int MAG_W = 5;

    // S.1111.111 with the sign bit excluded
    localparam logic [6:0] NAN_PATTERN = 7'h7F;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
        logic             zero;
        logic             nan;
    } s1_payload_t;

    // Biased code of a clamped k, wrapped to 4 bits (k=-7 -> 0, k=8 -> 15)
    function automatic logic [CODE_W-1:0] biased_code(input logic signed [5:0] k);
        return k[CODE_W-1:0] + CODE_W'(CODE_BIAS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp8_round_mag.sv
`default_nettype none
// ============================================================================
// Module      : fp8_round_mag
// Description : Combinational e4m3 magnitude rounder. Rounds |x| to the
//               nearest integer (ties away from zero); any result above 8
//               reports 16 as an overflow marker. Also detects exact zero
//               and NaN.
// Ports       : exp_field  [3:0] in  - biased exponent
//               mant_field [2:0] in  - mantissa
//               mag        [4:0] out - rounded magnitude (16 = overflow)
//               is_zero          out - exponent and mantissa both zero
//               is_nan           out - exponent/mantissa equal NaN pattern
// Revision    : 1.0  initial release
// ============================================================================
module fp8_round_mag
    import fp8_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_field,
    input  logic [MANT_W-1:0] mant_field,
    output logic [MAG_W-1:0]  mag,
    output logic              is_zero,
    output logic              is_nan
);

    logic [3:0] mant_plus_one;

    always_comb begin
        mag           = 5'd0;
        mant_plus_one = {1'b0, mant_field} + 4'd1;
        case (exp_field)
            4'd6:  mag = 5'd1;                                 // [0.5, 1)
            4'd7:  mag = mant_field[2] ? 5'd2 : 5'd1;          // 1.5 ties up
            4'd8: begin                                        // step 0.25
                if (mant_field <= 3'd1)
                    mag = 5'd2;
                else if (mant_field <= 3'd5)
                    mag = 5'd3;
                else
                    mag = 5'd4;
            end
            // step 0.5: 4 + M/2 rounded half-up == 4 + (M+1)/2
            4'd9:  mag = 5'd4 + {2'b00, mant_plus_one[3:1]};
            4'd10: mag = (mant_field == 3'd0) ? 5'd8 : 5'd16;
            4'd11, 4'd12, 4'd13, 4'd14, 4'd15: mag = 5'd16;
            default: mag = 5'd0;                               // |x| < 0.5
        endcase
    end

    assign is_zero = ({exp_field, mant_field} == 7'd0);
    assign is_nan  = ({exp_field, mant_field} == NAN_PATTERN);

endmodule
`default_nettype wire

// File: rtl/fp8_to_int_code.sv
`default_nettype none
// ============================================================================
// Module      : fp8_to_int_code
// Description : Two-stage pipelined e4m3 -> biased integer exponent code.
//               S1 registers sign, rounded magnitude and zero/NaN flags; S2
//               applies the sign, clamps k to [-7, 8] and registers k+7 plus
//               the zero/sat/nan flags. Valid/ready on both sides, one
//               result per cycle.
// Parameters  : OUT_REG_RESET_CODE - out_code value after reset
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready/in_data[7:0]   - e4m3 input stream
//               out_valid/out_ready              - output handshake
//               out_code[3:0], out_zero, out_sat, out_nan - result
//               stat_sat_cnt[15:0], stat_nan_cnt[15:0]
//                 - only when FP8_TO_INT_STATS_EN is defined
// Options     : FP8_TO_INT_STATS_EN - saturating counters of transferred
//               sat / nan results
// Revision    : 1.0  initial release
// ============================================================================
module fp8_to_int_code
    import fp8_pkg::*;
#(
    parameter logic [3:0] OUT_REG_RESET_CODE = 4'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [E4M3_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_zero,
    output logic              out_sat,
`ifdef FP8_TO_INT_STATS_EN
    output logic [15:0]       stat_sat_cnt,
    output logic [15:0]       stat_nan_cnt,
`endif
    output logic              out_nan
);

    localparam logic signed [5:0] K_MAX = 6'(CODE_MAX_K);
    localparam logic signed [5:0] K_MIN = 6'(CODE_MIN_K);

    // ---------------- Stage 1 ----------------
    logic             s1_valid;
    s1_payload_t      s1;
    logic             s1_ready;
    logic             s2_ready;
    logic [MAG_W-1:0] rnd_mag;
    logic             rnd_zero;
    logic             rnd_nan;

    fp8_round_mag u_round (
        .exp_field  (in_data[EXP_MSB:EXP_LSB]),
        .mant_field (in_data[MANT_MSB:MANT_LSB]),
        .mag        (rnd_mag),
        .is_zero    (rnd_zero),
        .is_nan     (rnd_nan)
    );

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1.sign <= in_data[SIGN_BIT];
                s1.mag  <= rnd_mag;
                s1.zero <= rnd_zero;
                s1.nan  <= rnd_nan;
            end
        end
    end

    // ---------------- Stage 2 ----------------
    logic signed [5:0]  k_raw;
    logic signed [5:0]  k_clamped;
    logic [CODE_W-1:0]  code_next;
    logic               sat_next;

    always_comb begin
        // -0 yields k_raw = 0, so it lands on code 7 like +0
        k_raw     = s1.sign ? -$signed({1'b0, s1.mag}) : $signed({1'b0, s1.mag});
        k_clamped = k_raw;
        sat_next  = 1'b0;
        if (k_raw > K_MAX) begin
            k_clamped = K_MAX;
            sat_next  = 1'b1;
        end else if (k_raw < K_MIN) begin
            k_clamped = K_MIN;
            sat_next  = 1'b1;
        end
        code_next = biased_code(k_clamped);
        // NaN overrides the numeric path so the flags stay exclusive
        if (s1.nan) begin
            code_next = '0;
            sat_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= OUT_REG_RESET_CODE;
            out_zero  <= 1'b0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_code <= code_next;
                out_zero <= s1.zero;
                out_sat  <= sat_next;
                out_nan  <= s1.nan;
            end
        end
    end

`ifdef FP8_TO_INT_STATS_EN
    // Only transferred results count; a stalled output is seen once
    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_sat_cnt <= 16'd0;
            stat_nan_cnt <= 16'd0;
        end else begin
            if (out_xfer && out_sat && (stat_sat_cnt != 16'hFFFF))
                stat_sat_cnt <= stat_sat_cnt + 16'd1;
            if (out_xfer && out_nan && (stat_nan_cnt != 16'hFFFF))
                stat_nan_cnt <= stat_nan_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp8_to_int_code.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp8_to_int_code
// Description : Self-checking bench for fp8_to_int_code. A real-arithmetic
//               model derives each expected result from the e4m3 value;
//               a negedge scoreboard compares every output transfer.
//               Directed vectors carry hand-computed literals.
//               Statistics checks compile when FP8_TO_INT_STATS_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp8_to_int_code;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_code;
    logic       out_zero;
    logic       out_sat;
    logic       out_nan;
`ifdef FP8_TO_INT_STATS_EN
    logic [15:0] stat_sat_cnt;
    logic [15:0] stat_nan_cnt;
`endif

    fp8_to_int_code #(.OUT_REG_RESET_CODE(4'd7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_zero  (out_zero),
        .out_sat   (out_sat),
`ifdef FP8_TO_INT_STATS_EN
        .stat_sat_cnt (stat_sat_cnt),
        .stat_nan_cnt (stat_nan_cnt),
`endif
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Expected {code[3:0], zero, sat, nan} from the numeric value of x
    function automatic logic [6:0] model(input logic [7:0] d);
        int  e;
        int  m;
        int  k;
        real mag;
        e = int'(d[6:3]);
        m = int'(d[2:0]);
        if (d[6:0] == 7'h7F) return {4'd0, 3'b001};
        if (d[6:0] == 7'h00) return {4'd7, 3'b100};
        if (e == 0)
            mag = (m / 8.0) * (2.0 ** (-6));
        else
            mag = (1.0 + m / 8.0) * (2.0 ** (e - 7));
        k = $rtoi($floor(mag + 0.5));
        if (d[7]) k = -k;
        if (k > 8)  return {4'd15, 3'b010};
        if (k < -7) return {4'd0, 3'b010};
        return {4'(k + 7), 3'b000};
    endfunction

    // Scoreboard: expected results queued on accept, compared on transfer
    logic [6:0] sb[$];
    logic [3:0] drained[$];
    bit         record_en = 1'b0;

    always @(negedge clk) begin : monitor
        logic [6:0] exp_v;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {out_code, out_zero, out_sat, out_nan}, 7'h7F ^ {out_code, out_zero, out_sat, out_nan});
                end else begin
                    exp_v = sb.pop_front();
                    check("scoreboard", {out_code, out_zero, out_sat, out_nan}, exp_v);
                end
                if (record_en) drained.push_back(out_code);
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
        end
    end

    int cyc = 0;
    bit bp_en = 1'b0;

    // Present d until accepted (bounded); returns #1 after the accepting edge
    task automatic send(input logic [7:0] d);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            if (bp_en) out_ready = (cyc % 3) != 2;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (!out_valid && sb.size() == 0) break;
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer with a 2-cycle latency and literal expectations
    task automatic single(input logic [7:0] d, input logic [6:0] exp_v);
        check($sformatf("model_%02h", d), model(d), exp_v);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        check("single_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_not_early", out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        check($sformatf("single_%02h", d), {out_code, out_zero, out_sat, out_nan}, exp_v);
        @(posedge clk);
        #1;
    endtask

    localparam int NSINGLE = 21;
    logic [7:0] s_in  [NSINGLE] = '{8'h38, 8'h44, 8'hC0, 8'h3C, 8'h4A, 8'h4B, 8'h30,
                                    8'h28, 8'h01, 8'h00, 8'h80, 8'h58, 8'hD8, 8'hD0,
                                    8'h7F, 8'hFF, 8'h50, 8'h48, 8'hC8, 8'hCE, 8'h4F};
    logic [6:0] s_exp [NSINGLE] = '{{4'd8, 3'b000}, {4'd10, 3'b000}, {4'd5, 3'b000},
                                    {4'd9, 3'b000}, {4'd12, 3'b000}, {4'd13, 3'b000},
                                    {4'd8, 3'b000}, {4'd7, 3'b000},  {4'd7, 3'b000},
                                    {4'd7, 3'b100}, {4'd7, 3'b100},  {4'd15, 3'b010},
                                    {4'd0, 3'b010}, {4'd0, 3'b010},  {4'd0, 3'b001},
                                    {4'd0, 3'b001}, {4'd15, 3'b000}, {4'd11, 3'b000},
                                    {4'd3, 3'b000}, {4'd0, 3'b000},  {4'd15, 3'b000}};

    initial begin
        logic [3:0] want_drain [4];
        want_drain = '{4'd8, 4'd9, 4'd10, 4'd11};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 7);
        check("rst_flags", {out_zero, out_sat, out_nan}, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed single transfers
        for (int i = 0; i < NSINGLE; i++) single(s_in[i], s_exp[i]);

        // Backpressure: two accepts fill the pipe, output holds code 8
        record_en = 1'b1;
        drained.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h38;
        @(negedge clk);
        check("bp_accept0", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = 8'h40;
        @(negedge clk);
        check("bp_accept1", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = 8'h44;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_code", out_code, 8);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'h44);
        send(8'h48);
        drain();
        record_en = 1'b0;
        check("bp_drain_count", drained.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < drained.size()) check("bp_drain_order", drained[i], want_drain[i]);

        // Full sweep of every encoding under an irregular out_ready
        bp_en = 1'b1;
        for (int i = 0; i < 256; i++) send(8'(i));
        bp_en = 1'b0;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(8'h38);
        send(8'h58);
        @(negedge clk);
        check("mid_full", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_code", out_code, 7);
        check("mid_rst_flags", {out_zero, out_sat, out_nan}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_replay", out_valid, 0);

`ifdef FP8_TO_INT_STATS_EN
        check("stat_sat_reset", stat_sat_cnt, 0);
        check("stat_nan_reset", stat_nan_cnt, 0);
        send(8'h58);
        send(8'hD8);
        drain();
        out_ready = 1'b0;
        send(8'hD0);
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("stat_sat_stalled", stat_sat_cnt, 2);
        check("stat_nan_stalled", stat_nan_cnt, 0);
        out_ready = 1'b1;
        send(8'h7F);
        drain();
        check("stat_sat_final", stat_sat_cnt, 3);
        check("stat_nan_final", stat_nan_cnt, 2);
`endif

        check("sb_empty_at_end", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
